// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray-code sequencer: command op-codes, FSM state
// type and the binary-to-Gray helper.
package gray_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Widest position supported; callers truncate the result to their width.
  localparam int MAX_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_dwell_timer.sv
// Loadable down-counter that stops at zero; zero flags that a step is due.
module gray_seq_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gray_seq_fsm.sv
// Gray-code position sequencer with valid/ready command interface.
// Optional abort input is enabled by defining GRAY_SEQ_ABORT_EN.
module gray_seq_fsm
  import gray_seq_pkg::*;
#(
  parameter  int STATE_W = 4,
  parameter  int CNT_W   = 4,
  parameter  int DWELL_W = 4,
  localparam int ARG_W   = (STATE_W > CNT_W) ? STATE_W : CNT_W,
  localparam int N_POS   = 1 << STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready is !busy, so offers made during a run are ignored and the source
  // holds its command until the block returns to idle.
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ARG_W-1:0]   cmd_arg,
  input  logic [DWELL_W-1:0] cmd_dwell,
`ifdef GRAY_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [STATE_W-1:0] pos_gray,
  output logic [N_POS-1:0]   out,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [STATE_W-1:0] IDX_MAX  = '1;
  localparam logic [N_POS-1:0]   ONE_HOT0 = N_POS'(1);

  state_t             state;
  logic [STATE_W-1:0] idx;
  logic [STATE_W-1:0] idx_next;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   cmd_count;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] timer_val;
  logic               dir_down;
  logic               accept;
  logic               start_run;
  logic               step_due;
  logic               abort_hit;
  logic               wrap_next;
  logic               timer_load;
  logic               timer_zero;

  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_count = cmd_arg[CNT_W-1:0];
  assign start_run = accept && ((cmd_op == OP_UP) || (cmd_op == OP_DOWN))
                     && (cmd_count != '0);

`ifdef GRAY_SEQ_ABORT_EN
  assign abort_hit = (state == RUN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort wins over a step falling due on the same edge.
  assign step_due   = (state == RUN) && timer_zero && !abort_hit;
  assign timer_load = start_run || step_due;
  assign timer_val  = start_run ? cmd_dwell : dwell_q;

  gray_seq_dwell_timer #(
    .W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (state == RUN),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    if (accept && (cmd_op == OP_LOAD)) begin
      idx_next = cmd_arg[STATE_W-1:0];
    end else if (step_due) begin
      if (dir_down) begin
        idx_next  = idx - 1'b1;
        wrap_next = (idx == '0);
      end else begin
        idx_next  = idx + 1'b1;
        wrap_next = (idx == IDX_MAX);
      end
    end
  end

  // Outputs are registered from idx_next so they move on the same edge as idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pos_gray  <= '0;
      out       <= ONE_HOT0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      dwell_q   <= '0;
      dir_down  <= 1'b0;
    end else begin
      idx      <= idx_next;
      pos_gray <= STATE_W'(bin2gray(MAX_W'(idx_next)));
      out      <= ONE_HOT0 << idx_next;
      wrap     <= wrap_next;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && ((cmd_op == OP_UP) || (cmd_op == OP_DOWN))) begin
            if (cmd_count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              remaining <= cmd_count;
              dwell_q   <= cmd_dwell;
              dir_down  <= (cmd_op == OP_DOWN);
            end
          end
        end
        RUN: begin
          if (abort_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_due) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_fsm.sv
// Bench for gray_seq_fsm: per-cycle expected trace built from the step timeline
// (step k at accept + k*(dwell+1)) and compared against all outputs.
`timescale 1ns/1ps
module tb_gray_seq_fsm;
  import gray_seq_pkg::*;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 4;
  localparam int DWELL_W = 4;
  localparam int N_POS   = 16;
  localparam int EW      = STATE_W + N_POS + 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_arg;
  logic [DWELL_W-1:0] cmd_dwell;
  logic [STATE_W-1:0] pos_gray;
  logic [N_POS-1:0]   out;
  logic               busy;
  logic               wrap;
  logic               done;
`ifdef GRAY_SEQ_ABORT_EN
  logic               abort;
`endif

  logic [EW-1:0] act;
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int m_idx    = 0;

  assign act = {pos_gray, out, busy, done, wrap};

  always #5 clk = ~clk;

  gray_seq_fsm #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_dwell (cmd_dwell),
`ifdef GRAY_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .pos_gray  (pos_gray),
    .out       (out),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  // Expected output vector for a position index: Gray = i ^ (i>>1), one-hot = 1<<i.
  function automatic logic [EW-1:0] model_vec(input int i, input bit b, input bit dn, input bit w);
    logic [STATE_W-1:0] bi;
    logic [N_POS-1:0]   oh;
    bi    = STATE_W'(i);
    oh    = '0;
    oh[i] = 1'b1;
    return {bi ^ (bi >> 1), oh, b, dn, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int arg, input int dwell);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = 4'(arg);
    cmd_dwell = 4'(dwell);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  // Compare up to 'limit' queued entries, one per clock edge.
  task automatic check_queue(input string name, input bit poke, input int limit);
    logic [EW-1:0] e;
    int cnt;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < limit) begin
      e = exp_q.pop_front();
      cnt++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s step %0d: got {gray,out,busy,done,wrap}=%h expected %h", name, cnt, act, e);
      end
      checks++;
      if (cmd_ready !== !e[2]) begin
        failures++;
        $display("FAIL %s_ready step %0d: got %b expected %b", name, cnt, cmd_ready, !e[2]);
      end
      if (exp_q.size() > 0 && cnt < limit) begin
        if (poke) begin
          cmd_valid = 1'($urandom_range(0, 1));
          cmd_op    = 2'($urandom_range(0, 3));
          cmd_arg   = 4'($urandom_range(0, 15));
          cmd_dwell = 4'($urandom_range(0, 15));
        end
        tick();
        cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic build_run(input logic [1:0] op, input int n, input int d);
    int total;
    bit w;
    total = n * (d + 1);
    if (n == 0) begin
      exp_q.push_back(model_vec(m_idx, 1'b0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(model_vec(m_idx, 1'b1, 1'b0, 1'b0));
      for (int e = 1; e <= total; e++) begin
        w = 1'b0;
        if (e % (d + 1) == 0) begin
          if (op == OP_UP) begin
            w     = (m_idx == N_POS - 1);
            m_idx = (m_idx + 1) % N_POS;
          end else begin
            w     = (m_idx == 0);
            m_idx = (m_idx + N_POS - 1) % N_POS;
          end
        end
        exp_q.push_back(model_vec(m_idx, e < total, e == total, w));
      end
    end
  endtask

  task automatic run_updown(input string name, input logic [1:0] op, input int n, input int d, input bit poke);
    issue(op, n, d);
    build_run(op, n, d);
    check_queue(name, poke, 1000);
  endtask

  task automatic do_load(input string name, input int a);
    issue(OP_LOAD, a, $urandom_range(0, 15));
    m_idx = a;
    exp_q.push_back(model_vec(m_idx, 1'b0, 1'b0, 1'b0));
    check_queue(name, 1'b0, 1000);
  endtask

  task automatic idle_cycles(input string name, input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      exp_q.push_back(model_vec(m_idx, 1'b0, 1'b0, 1'b0));
      check_queue(name, 1'b0, 1000);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
    cmd_dwell = '0;
`ifdef GRAY_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) tick();
    m_idx = 0;
    exp_q.push_back(model_vec(0, 1'b0, 1'b0, 1'b0));
    check_queue("reset", 1'b0, 1000);
    rst = 1'b0;
    idle_cycles("reset_idle", 1);
  endtask

  task automatic test_up_basic();
    run_updown("up3_d0", OP_UP, 3, 0, 1'b0);
  endtask

  task automatic test_down_wrap();
    do_load("load0", 0);
    run_updown("down1_wrap", OP_DOWN, 1, 0, 1'b0);
    run_updown("up1_wrap", OP_UP, 1, 0, 1'b0);
  endtask

  task automatic test_load_dwell();
    do_load("load9", 9);
    run_updown("up2_d2_poke", OP_UP, 2, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_updown("b2b_first", OP_DOWN, 2, 1, 1'b1);
    run_updown("b2b_second", OP_UP, 1, 1, 1'b0);
    run_updown("b2b_third", OP_UP, 2, 0, 1'b0);
  endtask

  task automatic test_zero_count_nop();
    run_updown("up_cnt0", OP_UP, 0, 3, 1'b0);
    run_updown("down_cnt0", OP_DOWN, 0, 0, 1'b0);
    issue(OP_NOP, 7, 2);
    exp_q.push_back(model_vec(m_idx, 1'b0, 1'b0, 1'b0));
    check_queue("nop", 1'b0, 1000);
  endtask

  task automatic test_reset_mid_run(input string name, input int n, input int d);
    issue(OP_UP, n, d);
    build_run(OP_UP, n, d);
    check_queue(name, 1'b0, 2);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_idx = 0;
    exp_q.push_back(model_vec(0, 1'b0, 1'b0, 1'b0));
    check_queue(name, 1'b0, 1000);
    idle_cycles(name, 2);
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 3);
      if (op == 3) begin
        do_load("rnd_load", $urandom_range(0, N_POS - 1));
      end else if (op == 0) begin
        idle_cycles("rnd_idle", $urandom_range(1, 2));
      end else begin
        run_updown("rnd_run", (op == 1) ? OP_UP : OP_DOWN,
                   $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
  endtask

`ifdef GRAY_SEQ_ABORT_EN
  task automatic test_abort();
    int start;
    abort = 1'b1;
    do_load("abort_idle_load", 5);
    abort = 1'b0;
    start = m_idx;
    issue(OP_UP, 4, 0);
    build_run(OP_UP, 4, 0);
    check_queue("abort_pre", 1'b0, 2);
    exp_q.delete();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_idx = (start + 1) % N_POS;
    exp_q.push_back(model_vec(m_idx, 1'b0, 1'b0, 1'b0));
    check_queue("abort_hit", 1'b0, 1000);
    idle_cycles("abort_after", 2);
  endtask
`endif

  initial begin
    test_reset();
    test_up_basic();
    test_down_wrap();
    test_load_dwell();
    test_back_to_back();
    test_zero_count_nop();
    test_reset_mid_run("rst_mid_d3", 5, 3);
    test_reset_mid_run("rst_mid_d0", 5, 0);
    test_random();
`ifdef GRAY_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
